// File: rtl/aes_pkg.sv
// AES-128 shared definitions for the inverse-cipher core: round count,
// FSM encoding, round constants and the byte/state transforms.
// State layout: bits [127:120] are byte 0 (row 0, col 0), column-major.
package aes_pkg;

  localparam int NR = 10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    KEXP = 2'd1,
    DEC  = 2'd2
  } state_t;

  // RCON[1..10]; anything else returns zero
  function automatic logic [7:0] rcon(input logic [3:0] idx);
    logic [7:0] r;
    case (idx)
      4'd1:    r = 8'h01;
      4'd2:    r = 8'h02;
      4'd3:    r = 8'h04;
      4'd4:    r = 8'h08;
      4'd5:    r = 8'h10;
      4'd6:    r = 8'h20;
      4'd7:    r = 8'h40;
      4'd8:    r = 8'h80;
      4'd9:    r = 8'h1b;
      4'd10:   r = 8'h36;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254 (0 maps to 0)
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] r;
    logic [7:0] b;
    r = 8'h01;
    b = a;
    for (int i = 0; i < 8; i++) begin
      if (i != 0) r = gmul(r, b);
      b = gmul(b, b);
    end
    return r;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] b;
    b = gf_inv(x);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] y);
    logic [7:0] b;
    b = {y[6:0], y[7]} ^ {y[4:0], y[7:5]} ^ {y[1:0], y[7:2]} ^ 8'h05;
    return gf_inv(b);
  endfunction

  // Row r rotates right by r columns
  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c-r+4)%4)+r) -: 8];
    return o;
  endfunction

  function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = inv_sbox(s[127-8*i -: 8]);
    return o;
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
      o[119-32*c -: 8] = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
      o[111-32*c -: 8] = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
      o[103-32*c -: 8] = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);
    end
    return o;
  endfunction

endpackage

// File: rtl/aes_key_step.sv
// One AES-128 key-schedule step. dir=0 derives round key i from i-1,
// dir=1 recovers round key i-1 from i (rcon is RCON[i] in both cases).
module aes_key_step
  import aes_pkg::*;
(
  input  logic [127:0] keyIn,
  input  logic [7:0]   rcon,
  input  logic         dir,
  output logic [127:0] keyOut
);

  logic [31:0] w0, w1, w2, w3, lastW, g, n0;

  assign {w0, w1, w2, w3} = keyIn;

  // The SubWord/RotWord input is old w3: given directly going forward,
  // recovered as w3^w2 going backward, so one set of S-boxes serves both.
  always_comb begin
    lastW  = dir ? (w3 ^ w2) : w3;
    g      = {sbox(lastW[23:16]), sbox(lastW[15:8]), sbox(lastW[7:0]), sbox(lastW[31:24])}
             ^ {rcon, 24'h000000};
    n0     = w0 ^ g;
    keyOut = dir ? {n0, w1 ^ w0, w2 ^ w1, w3 ^ w2}
                 : {n0, n0 ^ w1, n0 ^ w1 ^ w2, n0 ^ w1 ^ w2 ^ w3};
  end

endmodule

// File: rtl/aes_inv_core.sv
// Iterative AES-128 decryption core: forward-expands the key to rk10,
// then runs ten inverse rounds, stepping the key schedule backwards.
// Optional macro AES_INV_KEY_CACHE_EN keeps the last key/rk10 pair so a
// repeated key skips key expansion.
module aes_inv_core
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] cipher_text,
  input  logic [127:0] cipher_key,
  output logic         busy,
  output logic         done,
  output logic [127:0] plain_text
);

  localparam logic [3:0] LAST_KEXP = 4'(NR);

  state_t       state, nextState;
  logic [3:0]   cnt;
  logic [127:0] ctReg, rkReg, sReg;
  logic         first;
  logic         finPend;   // last round done, result goes out next edge
  logic         accept, cacheHit;
  logic [7:0]   rconFwd, rconInv;
  logic [127:0] rkFwd, rkInv, sIn, tRound;
  logic [127:0] cacheRk10;

  // finPend keeps start blocked during the output register cycle
  assign accept  = (state == IDLE) && start && !finPend;
  assign rconFwd = rcon(cnt);
  assign rconInv = rcon(cnt + 4'd1);

  aes_key_step uFwd (.keyIn(rkReg), .rcon(rconFwd), .dir(1'b0), .keyOut(rkFwd));
  aes_key_step uInv (.keyIn(rkReg), .rcon(rconInv), .dir(1'b1), .keyOut(rkInv));

`ifdef AES_INV_KEY_CACHE_EN
  logic         cacheVld;
  logic [127:0] cacheKey, keyReg;

  assign cacheHit = cacheVld && (cipher_key == cacheKey);

  // Remember the key of the current run and its rk10 once expansion ends
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cacheVld  <= 1'b0;
      cacheKey  <= '0;
      cacheRk10 <= '0;
      keyReg    <= '0;
    end else begin
      if (accept) keyReg <= cipher_key;
      if (state == KEXP && cnt == LAST_KEXP) begin
        cacheKey  <= keyReg;
        cacheRk10 <= rkFwd;
        cacheVld  <= 1'b1;
      end
    end
  end
`else
  assign cacheHit  = 1'b0;
  assign cacheRk10 = '0;
`endif

  // Round datapath: first round folds in the rk10 whitening
  always_comb begin
    sIn    = first ? (ctReg ^ rkReg) : sReg;
    tRound = inv_sub_bytes(inv_shift_rows(sIn)) ^ rkInv;
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= nextState;
  end

  // Next-state logic; out-of-range counters fall back to IDLE
  always_comb begin
    nextState = state;
    case (state)
      IDLE: if (accept) nextState = cacheHit ? DEC : KEXP;
      KEXP: begin
        if (cnt == 4'd0 || cnt > LAST_KEXP) nextState = IDLE;
        else if (cnt == LAST_KEXP)          nextState = DEC;
      end
      DEC:  if (cnt == 4'd0 || cnt > 4'd9)  nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    busy = (state != IDLE) || finPend;
  end

  // Datapath and counter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt        <= '0;
      ctReg      <= '0;
      rkReg      <= '0;
      sReg       <= '0;
      first      <= 1'b0;
      finPend    <= 1'b0;
      done       <= 1'b0;
      plain_text <= '0;
    end else begin
      done    <= finPend;
      finPend <= 1'b0;
      if (finPend) plain_text <= sReg;
      case (state)
        IDLE: begin
          if (accept) begin
            ctReg <= cipher_text;
            first <= 1'b1;
            if (cacheHit) begin
              rkReg <= cacheRk10;
              cnt   <= 4'd9;
            end else begin
              rkReg <= cipher_key;
              cnt   <= 4'd1;
            end
          end
        end
        KEXP: begin
          rkReg <= rkFwd;
          if (cnt == LAST_KEXP) cnt <= 4'd9;
          else                  cnt <= cnt + 4'd1;
        end
        DEC: begin
          rkReg <= rkInv;
          first <= 1'b0;
          if (cnt == 4'd0) begin
            sReg    <= tRound;
            finPend <= 1'b1;
          end else begin
            sReg <= inv_mix_columns(tRound);
            cnt  <= cnt - 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_inv_core.sv
// Self-checking bench for aes_inv_core. The reference is a forward AES-128
// encryption model: random plaintexts are encrypted here and the DUT must
// recover them. Honours AES_INV_KEY_CACHE_EN for expected latency.
module tb_aes_inv_core;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [127:0] cipher_text = '0;
  logic [127:0] cipher_key = '0;
  logic         busy, done;
  logic [127:0] plain_text;

  int nVec = 0;
  int nErr = 0;

  logic [7:0]   sb [256];
  bit           mVld = 1'b0;
  logic [127:0] mKey = '0;

  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;

  always #5 clk = ~clk;

  aes_inv_core dut (
    .clk(clk), .rst(rst), .start(start), .cipher_text(cipher_text),
    .cipher_key(cipher_key), .busy(busy), .done(done), .plain_text(plain_text)
  );

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // S-box built by walking the multiplicative group with generator 3
  task automatic build_sbox();
    logic [7:0] p, q, x;
    p = 8'h01;
    q = 8'h01;
    do begin
      p = p ^ xt(p);
      q = q ^ {q[6:0], 1'b0};
      q = q ^ {q[5:0], 2'b00};
      q = q ^ {q[3:0], 4'h0};
      if (q[7]) q = q ^ 8'h09;
      x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
      sb[p] = x ^ 8'h63;
    end while (p != 8'h01);
    sb[0] = 8'h63;
  endtask

  // Textbook AES-128 cipher on a byte array
  function automatic logic [127:0] aes_enc(input logic [127:0] key, input logic [127:0] pt);
    logic [7:0] w [176];
    logic [7:0] s [16];
    logic [7:0] t [16];
    logic [7:0] tmp [4];
    logic [7:0] rc, a0, a1, a2, a3;
    logic [127:0] o;
    for (int i = 0; i < 16; i++) w[i] = key[127-8*i -: 8];
    rc = 8'h01;
    for (int i = 16; i < 176; i += 4) begin
      for (int j = 0; j < 4; j++) tmp[j] = w[i-4+j];
      if (i % 16 == 0) begin
        a0 = tmp[0];
        tmp[0] = sb[tmp[1]] ^ rc;
        tmp[1] = sb[tmp[2]];
        tmp[2] = sb[tmp[3]];
        tmp[3] = sb[a0];
        rc = xt(rc);
      end
      for (int j = 0; j < 4; j++) w[i+j] = w[i-16+j] ^ tmp[j];
    end
    for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ w[i];
    for (int rnd = 1; rnd <= 10; rnd++) begin
      for (int i = 0; i < 16; i++) s[i] = sb[s[i]];
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) t[c*4+r] = s[((c+r)%4)*4+r];
      for (int c = 0; c < 4; c++) begin
        a0 = t[c*4]; a1 = t[c*4+1]; a2 = t[c*4+2]; a3 = t[c*4+3];
        if (rnd < 10) begin
          s[c*4]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
          s[c*4+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
          s[c*4+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
          s[c*4+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
        end else begin
          s[c*4] = a0; s[c*4+1] = a1; s[c*4+2] = a2; s[c*4+3] = a3;
        end
      end
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[16*rnd+i];
    end
    o = '0;
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = s[i];
    return o;
  endfunction

  function automatic int exp_lat(input logic [127:0] key);
`ifdef AES_INV_KEY_CACHE_EN
    return (mVld && key == mKey) ? 11 : 21;
`else
    return 21;
`endif
  endfunction

  // Start must already be driven; waits for done with a cycle budget
  task automatic wait_done(output int lat, output logic [127:0] pt,
                           output bit busyGap, output bit busyAtDone);
    lat = -1; pt = '0; busyGap = 1'b0; busyAtDone = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cipher_text = {$urandom, $urandom, $urandom, $urandom};
    cipher_key  = {$urandom, $urandom, $urandom, $urandom};
    if (!busy) busyGap = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (done) begin
        lat = k; pt = plain_text; busyAtDone = busy;
        break;
      end
      if (!busy) busyGap = 1'b1;
    end
  endtask

  task automatic run_check(input string name, input logic [127:0] key,
                           input logic [127:0] ct, input logic [127:0] pt);
    int lat, el;
    logic [127:0] got;
    bit gap, bd;
    el = exp_lat(key);
    cipher_key = key; cipher_text = ct; start = 1'b1;
    wait_done(lat, got, gap, bd);
    nVec++;
    if (lat !== el) begin nErr++; $display("FAIL %s latency: got %0d expected %0d", name, lat, el); end
    nVec++;
    if (got !== pt) begin nErr++; $display("FAIL %s plain_text: got %h expected %h", name, got, pt); end
    nVec++;
    if (gap || bd) begin nErr++; $display("FAIL %s busy: gap=%0d busyAtDone=%0d expected 0 0", name, gap, bd); end
    mVld = 1'b1; mKey = key;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    nVec++;
    if (busy !== 1'b0) begin nErr++; $display("FAIL reset busy: got %b expected 0", busy); end
    nVec++;
    if (done !== 1'b0) begin nErr++; $display("FAIL reset done: got %b expected 0", done); end
    nVec++;
    if (plain_text !== 128'h0) begin nErr++; $display("FAIL reset plain_text: got %h expected 0", plain_text); end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    nVec++;
    if (busy !== 1'b0) begin nErr++; $display("FAIL idle busy: got %b expected 0", busy); end
  endtask

  task automatic test_fips();
    run_check("fips_c1", C1_KEY, C1_CT, C1_PT);
    run_check("fips_b", B_KEY, B_CT, B_PT);
  endtask

  task automatic test_start_while_busy();
    int el, lat, nDone;
    logic [127:0] got;
    bit gap;
    el = exp_lat(C1_KEY);
    cipher_key = C1_KEY; cipher_text = C1_CT; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    nDone = 0; lat = -1; got = '0; gap = 1'b0;
    for (int k = 1; k <= 45; k++) begin
      if (k == 5) begin start = 1'b1; cipher_text = B_CT; end
      if (k == 6) start = 1'b0;
      @(posedge clk); #1;
      if (done) begin
        nDone++;
        if (lat < 0) begin lat = k; got = plain_text; end
      end else if (lat < 0 && !busy) gap = 1'b1;
    end
    nVec++;
    if (nDone !== 1) begin nErr++; $display("FAIL ignore_start done count: got %0d expected 1", nDone); end
    nVec++;
    if (lat !== el) begin nErr++; $display("FAIL ignore_start latency: got %0d expected %0d", lat, el); end
    nVec++;
    if (got !== C1_PT) begin nErr++; $display("FAIL ignore_start plain_text: got %h expected %h", got, C1_PT); end
    nVec++;
    if (gap) begin nErr++; $display("FAIL ignore_start busy gap: got 1 expected 0"); end
    nVec++;
    if (plain_text !== C1_PT) begin nErr++; $display("FAIL ignore_start hold: got %h expected %h", plain_text, C1_PT); end
    mVld = 1'b1; mKey = C1_KEY;
  endtask

  task automatic test_reset_mid();
    int nDone;
    cipher_key = C1_KEY; cipher_text = C1_CT; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 1; k <= 12; k++) begin @(posedge clk); #1; end
    rst = 1'b1;
    #2;
    nVec++;
    if (busy !== 1'b0) begin nErr++; $display("FAIL abort busy: got %b expected 0", busy); end
    nVec++;
    if (plain_text !== 128'h0) begin nErr++; $display("FAIL abort plain_text: got %h expected 0", plain_text); end
    @(negedge clk);
    rst = 1'b0;
    mVld = 1'b0;
    nDone = 0;
    for (int k = 0; k < 30; k++) begin @(posedge clk); #1; if (done) nDone++; end
    nVec++;
    if (nDone !== 0) begin nErr++; $display("FAIL abort done count: got %0d expected 0", nDone); end
    run_check("after_abort", C1_KEY, C1_CT, C1_PT);
  endtask

  task automatic test_back_to_back();
    run_check("b2b_first", C1_KEY, C1_CT, C1_PT);
    nVec++;
    if (done !== 1'b1) begin nErr++; $display("FAIL b2b in done cycle: got %b expected 1", done); end
    run_check("b2b_second", B_KEY, B_CT, B_PT);
    run_check("b2b_third", B_KEY, B_CT, B_PT);
  endtask

  task automatic test_cache();
    run_check("cache_c1_a", C1_KEY, C1_CT, C1_PT);
    run_check("cache_c1_b", C1_KEY, C1_CT, C1_PT);
    run_check("cache_b", B_KEY, B_CT, B_PT);
  endtask

  task automatic test_random();
    logic [127:0] key, pt, prevKey;
    prevKey = B_KEY;
    for (int n = 0; n < 8; n++) begin
      key = (n % 3 == 2) ? prevKey : {$urandom, $urandom, $urandom, $urandom};
      pt  = {$urandom, $urandom, $urandom, $urandom};
      run_check($sformatf("rand%0d", n), key, aes_enc(key, pt), pt);
      prevKey = key;
    end
  endtask

  initial begin
    build_sbox();
    test_reset();
    test_fips();
    test_start_while_busy();
    test_reset_mid();
    test_back_to_back();
    test_cache();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end

endmodule
